// File: rtl/him_access_arbiter_if.sv
// rtl/him_access_arbiter_if.sv - requester, response and HIM command bundle for him_access_arbiter
interface him_access_arbiter_if #(
  parameter int ROWINDEXBITS_HIM = 10,
  parameter int NCOLS_HIM        = 128,
  parameter int MAXHITNBITS      = 3,
  parameter int TAGBITS          = 4
);
  logic                        wr_valid;
  logic                        wr_ready;
  logic [ROWINDEXBITS_HIM-1:0] wr_row;
  logic [NCOLS_HIM-1:0]        wr_hitInfo;
  logic [MAXHITNBITS-1:0]      wr_nOldHits;
  logic [MAXHITNBITS-1:0]      wr_nNewHits;

  logic                        rd_valid;
  logic                        rd_ready;
  logic [ROWINDEXBITS_HIM-1:0] rd_row;
  logic [TAGBITS-1:0]          rd_tag;

  logic                        rsp_valid;
  logic [NCOLS_HIM-1:0]        rsp_data;
  logic [TAGBITS-1:0]          rsp_tag;

  logic                        him_busy;
  logic                        him_writeRow;
  logic [ROWINDEXBITS_HIM-1:0] him_inputRowToWrite;
  logic [NCOLS_HIM-1:0]        him_inputHitInfo;
  logic [MAXHITNBITS-1:0]      him_nOldHits;
  logic [MAXHITNBITS-1:0]      him_nNewHits;
  logic                        him_readRow;
  logic [ROWINDEXBITS_HIM-1:0] him_inputRowToRead;
  logic [NCOLS_HIM-1:0]        him_hitInfo_read;

  modport slave (
    input  wr_valid, wr_row, wr_hitInfo, wr_nOldHits, wr_nNewHits,
    output wr_ready,
    input  rd_valid, rd_row, rd_tag,
    output rd_ready,
    output rsp_valid, rsp_data, rsp_tag,
    input  him_busy, him_hitInfo_read,
    output him_writeRow, him_inputRowToWrite, him_inputHitInfo, him_nOldHits, him_nNewHits,
    output him_readRow, him_inputRowToRead
  );

  modport master (
    output wr_valid, wr_row, wr_hitInfo, wr_nOldHits, wr_nNewHits,
    input  wr_ready,
    output rd_valid, rd_row, rd_tag,
    input  rd_ready,
    input  rsp_valid, rsp_data, rsp_tag,
    output him_busy, him_hitInfo_read,
    input  him_writeRow, him_inputRowToWrite, him_inputHitInfo, him_nOldHits, him_nNewHits,
    input  him_readRow, him_inputRowToRead
  );
endinterface

// File: rtl/him_access_arbiter.sv
// rtl/him_access_arbiter.sv - write-priority HIM arbiter with bounded write streak, tagged read return and drain sequencer
// Optional read-after-write row hazard window is built when HIM_ARB_HAZARD_EN is defined.
module him_access_arbiter #(
  parameter int ROWINDEXBITS_HIM = 10,
  parameter int NCOLS_HIM        = 128,
  parameter int MAXHITNBITS      = 3,
  parameter int TAGBITS          = 4,
  parameter int READ_LATENCY     = 4,
  parameter int MAX_WRITE_STREAK = 4,
  parameter int HAZARD_WINDOW    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic flush_req,
  output logic flush_done,
  output logic inflight,
  him_access_arbiter_if.slave bus
);
  localparam int STAGES     = READ_LATENCY + 1;
  localparam int STREAKBITS = $clog2(MAX_WRITE_STREAK + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state;
  logic [STREAKBITS-1:0] streak;
  logic [STAGES-1:0]     pipe_valid;
  logic [TAGBITS-1:0]    pipe_tag [STAGES];
  logic                  can_grant;
  logic                  streak_full;
  logic                  rd_hazard;
  logic                  wr_gnt;
  logic                  rd_gnt;

  assign can_grant   = (state == RUN) && !bus.him_busy;
  assign streak_full = (streak == STREAKBITS'(MAX_WRITE_STREAK));

`ifdef HIM_ARB_HAZARD_EN
  logic [HAZARD_WINDOW-1:0]    hist_valid;
  logic [ROWINDEXBITS_HIM-1:0] hist_row [HAZARD_WINDOW];

  // A same-row write requested this cycle always wins, so it counts as a hazard too.
  always_comb begin
    rd_hazard = bus.wr_valid && (bus.wr_row == bus.rd_row);
    for (int i = 0; i < HAZARD_WINDOW; i++) begin
      if (hist_valid[i] && (hist_row[i] == bus.rd_row)) rd_hazard = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || (state == IDLE)) begin
      hist_valid <= '0;
      for (int i = 0; i < HAZARD_WINDOW; i++) hist_row[i] <= '0;
    end else begin
      hist_valid  <= {hist_valid[HAZARD_WINDOW-2:0], wr_gnt};
      hist_row[0] <= bus.wr_row;
      for (int i = 1; i < HAZARD_WINDOW; i++) hist_row[i] <= hist_row[i-1];
    end
  end
`else
  assign rd_hazard = (HAZARD_WINDOW < 0);
`endif

  assign wr_gnt = can_grant && bus.wr_valid && (!bus.rd_valid || rd_hazard || !streak_full);
  assign rd_gnt = can_grant && bus.rd_valid && !rd_hazard && !wr_gnt;

  assign bus.wr_ready = wr_gnt;
  assign bus.rd_ready = rd_gnt;
  assign inflight     = (|pipe_valid) || bus.him_readRow;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                   <= IDLE;
      flush_done              <= 1'b0;
      streak                  <= '0;
      pipe_valid              <= '0;
      for (int i = 0; i < STAGES; i++) pipe_tag[i] <= '0;
      bus.him_writeRow        <= 1'b0;
      bus.him_inputRowToWrite <= '0;
      bus.him_inputHitInfo    <= '0;
      bus.him_nOldHits        <= '0;
      bus.him_nNewHits        <= '0;
      bus.him_readRow         <= 1'b0;
      bus.him_inputRowToRead  <= '0;
      bus.rsp_valid           <= 1'b0;
      bus.rsp_data            <= '0;
      bus.rsp_tag             <= '0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        IDLE:  if (enable && !flush_req) state <= RUN;
        RUN:   if (flush_req || !enable) state <= DRAIN;
        DRAIN: begin
          if ((pipe_valid == '0) && !bus.him_readRow && !bus.him_writeRow) begin
            state      <= DONE;
            flush_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (rd_gnt) begin
        streak <= '0;
      end else if (wr_gnt) begin
        if (!bus.rd_valid)    streak <= '0;
        else if (!streak_full) streak <= streak + 1'b1;
      end

      bus.him_writeRow <= wr_gnt;
      bus.him_readRow  <= rd_gnt;
      if (wr_gnt) begin
        bus.him_inputRowToWrite <= bus.wr_row;
        bus.him_inputHitInfo    <= bus.wr_hitInfo;
        bus.him_nOldHits        <= bus.wr_nOldHits;
        bus.him_nNewHits        <= bus.wr_nNewHits;
      end
      if (rd_gnt) bus.him_inputRowToRead <= bus.rd_row;

      // Stage 0 lines up with him_readRow; the last stage lines up with valid read data.
      pipe_valid  <= {pipe_valid[STAGES-2:0], rd_gnt};
      pipe_tag[0] <= bus.rd_tag;
      for (int i = 1; i < STAGES; i++) pipe_tag[i] <= pipe_tag[i-1];

      bus.rsp_valid <= pipe_valid[STAGES-1];
      if (pipe_valid[STAGES-1]) begin
        bus.rsp_data <= bus.him_hitInfo_read;
        bus.rsp_tag  <= pipe_tag[STAGES-1];
      end
    end
  end
endmodule

// File: tb/tb_him_access_arbiter.sv
// tb/tb_him_access_arbiter.sv - directed and randomized checks of him_access_arbiter against a behavioural model
module tb_him_access_arbiter;
  localparam int RB  = 10;
  localparam int NC  = 128;
  localparam int MB  = 3;
  localparam int TB  = 4;
  localparam int RL  = 4;
  localparam int MWS = 4;
  localparam int HW  = 4;

  typedef struct {
    int tag;
    int g;
  } rd_t;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic flush_req;
  logic flush_done;
  logic inflight;
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;

  him_access_arbiter_if #(.ROWINDEXBITS_HIM(RB), .NCOLS_HIM(NC), .MAXHITNBITS(MB), .TAGBITS(TB)) bus ();

  him_access_arbiter #(
    .ROWINDEXBITS_HIM(RB), .NCOLS_HIM(NC), .MAXHITNBITS(MB), .TAGBITS(TB),
    .READ_LATENCY(RL), .MAX_WRITE_STREAK(MWS), .HAZARD_WINDOW(HW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush_req(flush_req),
    .flush_done(flush_done), .inflight(inflight), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit, passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    flush_req = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_row = '0; bus.wr_hitInfo = '0; bus.wr_nOldHits = '0; bus.wr_nNewHits = '0;
    bus.rd_valid = 1'b0; bus.rd_row = '0; bus.rd_tag = '0;
    bus.him_busy = 1'b0; bus.him_hitInfo_read = '0;
  endtask

  task automatic restart();
    reset = 1'b0; enable = 1'b1; idle_inputs();
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; idle_inputs();
    bus.wr_valid = 1'b1; bus.rd_valid = 1'b1; bus.wr_row = 10'd3; bus.rd_row = 10'd4;
    repeat (3) tick();
    total++; if ({bus.wr_ready, bus.rd_ready} !== 2'b00) $display("FAIL reset_ready got=%b exp=00", {bus.wr_ready, bus.rd_ready}); else passed++;
    total++; if ({bus.him_writeRow, bus.him_readRow, bus.rsp_valid, flush_done, inflight} !== 5'b0)
      $display("FAIL reset_flags got=%b exp=00000", {bus.him_writeRow, bus.him_readRow, bus.rsp_valid, flush_done, inflight}); else passed++;
    total++; if (bus.rsp_data !== '0 || bus.rsp_tag !== '0 || bus.him_inputRowToWrite !== '0 || bus.him_inputRowToRead !== '0)
      $display("FAIL reset_fields got data=%h tag=%h exp=0", bus.rsp_data, bus.rsp_tag); else passed++;
    reset = 1'b1;
    #1;
    total++; if (bus.wr_ready !== 1'b0) $display("FAIL reset_idle_ready got=%b exp=0", bus.wr_ready); else passed++;
    tick();
    total++; if ({bus.wr_ready, bus.rd_ready} !== 2'b10) $display("FAIL reset_first_grant got=%b exp=10", {bus.wr_ready, bus.rd_ready}); else passed++;
    tick();
    total++; if (bus.him_writeRow !== 1'b1 || bus.him_inputRowToWrite !== 10'd3)
      $display("FAIL reset_first_cmd got=%b row=%0d exp=1 row=3", bus.him_writeRow, bus.him_inputRowToWrite); else passed++;
    idle_inputs();
  endtask

  task automatic test_single_read();
    restart();
    bus.rd_valid = 1'b1; bus.rd_row = 10'd5; bus.rd_tag = 4'd3;
    #1;
    total++; if (bus.rd_ready !== 1'b1) $display("FAIL single_grant got=%b exp=1", bus.rd_ready); else passed++;
    tick();
    bus.rd_valid = 1'b0;
    bus.him_hitInfo_read = '1;
    total++; if (bus.him_readRow !== 1'b1 || bus.him_inputRowToRead !== 10'd5 || bus.him_writeRow !== 1'b0)
      $display("FAIL single_cmd got rd=%b row=%0d wr=%b exp 1,5,0", bus.him_readRow, bus.him_inputRowToRead, bus.him_writeRow); else passed++;
    total++; if (inflight !== 1'b1) $display("FAIL single_inflight got=%b exp=1", inflight); else passed++;
    repeat (4) tick();
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_early_rsp got=%b exp=0", bus.rsp_valid); else passed++;
    bus.him_hitInfo_read = 128'hA5;
    tick();
    bus.him_hitInfo_read = '1;
    total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 128'hA5 || bus.rsp_tag !== 4'd3)
      $display("FAIL single_rsp got v=%b d=%h t=%0d exp 1,a5,3", bus.rsp_valid, bus.rsp_data, bus.rsp_tag); else passed++;
    tick();
    total++; if (bus.rsp_valid !== 1'b0 || inflight !== 1'b0)
      $display("FAIL single_after got v=%b inflight=%b exp 0,0", bus.rsp_valid, inflight); else passed++;
    idle_inputs();
  endtask

  task automatic test_starvation();
    int run = 0;
    restart();
    bus.wr_valid = 1'b1; bus.rd_valid = 1'b1; bus.wr_row = 10'd1; bus.rd_row = 10'd2;
    for (int i = 0; i < 12; i++) begin
      #1;
      total++; if ({bus.wr_ready, bus.rd_ready} !== ((i % 5 == 4) ? 2'b01 : 2'b10))
        $display("FAIL starve_pattern i=%0d got=%b exp=%b", i, {bus.wr_ready, bus.rd_ready}, (i % 5 == 4) ? 2'b01 : 2'b10); else passed++;
      run = bus.wr_ready ? run + 1 : 0;
      total++; if (run > MWS) $display("FAIL starve_streak got=%0d exp<=%0d", run, MWS); else passed++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_busy();
    restart();
    bus.wr_valid = 1'b1; bus.rd_valid = 1'b1; bus.wr_row = 10'd8; bus.rd_row = 10'd9;
    for (int i = 0; i < 3; i++) begin
      bus.him_busy = 1'b1;
      #1;
      total++; if ({bus.wr_ready, bus.rd_ready} !== 2'b00) $display("FAIL busy_ready i=%0d got=%b exp=00", i, {bus.wr_ready, bus.rd_ready}); else passed++;
      tick();
      total++; if ({bus.him_writeRow, bus.him_readRow} !== 2'b00) $display("FAIL busy_cmd i=%0d got=%b exp=00", i, {bus.him_writeRow, bus.him_readRow}); else passed++;
    end
    bus.him_busy = 1'b0;
    #1;
    total++; if (bus.wr_ready !== 1'b1) $display("FAIL busy_resume got=%b exp=1", bus.wr_ready); else passed++;
    tick();
    total++; if (bus.him_writeRow !== 1'b1 || bus.him_inputRowToWrite !== 10'd8)
      $display("FAIL busy_resume_cmd got=%b row=%0d exp 1,8", bus.him_writeRow, bus.him_inputRowToWrite); else passed++;
    idle_inputs();
  endtask

  task automatic test_hazard();
    int first;
    bit granted = 1'b0;
`ifdef HIM_ARB_HAZARD_EN
    first = HW + 1;
`else
    first = 1;
`endif
    restart();
    bus.wr_valid = 1'b1; bus.wr_row = 10'd7;
    #1;
    total++; if (bus.wr_ready !== 1'b1) $display("FAIL hazard_write got=%b exp=1", bus.wr_ready); else passed++;
    tick();
    bus.wr_valid = 1'b0; bus.rd_valid = 1'b1; bus.rd_row = 10'd7; bus.rd_tag = 4'd5;
    for (int k = 1; k <= 6; k++) begin
      #1;
      total++; if (bus.rd_ready !== (k == first)) $display("FAIL hazard_rd_ready k=%0d got=%b exp=%b", k, bus.rd_ready, k == first); else passed++;
      if (bus.rd_ready) granted = 1'b1;
      tick();
      if (granted) bus.rd_valid = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    int  g [3];
    int  got = 0;
    int  last_rsp = -10;
    bit  done = 1'b0;
    restart();
    for (int i = 0; i < 3; i++) begin
      bus.rd_valid = 1'b1; bus.rd_row = RB'(10 + i); bus.rd_tag = TB'(i + 1);
      bus.him_hitInfo_read = NC'(cyc * 7 + 1);
      #1;
      total++; if (bus.rd_ready !== 1'b1) $display("FAIL flush_grant i=%0d got=%b exp=1", i, bus.rd_ready); else passed++;
      g[i] = cyc;
      tick();
    end
    bus.rd_valid = 1'b0; flush_req = 1'b1;
    for (int k = 0; k < 30 && !done; k++) begin
      bus.him_hitInfo_read = NC'(cyc * 7 + 1);
      if (k == 1) begin
        flush_req = 1'b0; bus.rd_valid = 1'b1; bus.wr_valid = 1'b1;
      end
      #1;
      total++; if ({bus.wr_ready, bus.rd_ready} !== 2'b00) $display("FAIL flush_no_grant k=%0d got=%b exp=00", k, {bus.wr_ready, bus.rd_ready}); else passed++;
      if (bus.rsp_valid) begin
        total++;
        if (got >= 3 || bus.rsp_tag !== TB'(got + 1) || bus.rsp_data !== NC'((g[got] + RL + 1) * 7 + 1))
          $display("FAIL flush_rsp n=%0d got tag=%0d data=%h", got, bus.rsp_tag, bus.rsp_data);
        else passed++;
        got++;
        last_rsp = cyc;
      end
      if (flush_done) begin
        done = 1'b1;
        total++; if (got != 3 || cyc != last_rsp + 1)
          $display("FAIL flush_done_timing got rsps=%0d at=%0d exp rsps=3 at=%0d", got, cyc, last_rsp + 1); else passed++;
      end
      if (!done) tick();
    end
    if (!done) begin
      total++;
      $display("FAIL flush_timeout got flush_done=0 exp=1 within 30 cycles");
    end
    enable = 1'b0;
    tick();
    total++; if (flush_done !== 1'b0 || inflight !== 1'b0 || {bus.wr_ready, bus.rd_ready} !== 2'b00)
      $display("FAIL flush_idle got done=%b inflight=%b exp 0,0", flush_done, inflight); else passed++;
    idle_inputs();
  endtask

  task automatic test_random();
    rd_t              pend [$];
    int               hrow [$];
    int               hcyc [$];
    int               streak = 0;
    bit               ew = 0, er = 0, ersp = 0, w_wait = 0, r_wait = 0, wg, rg, hz;
    logic [RB-1:0]    ew_row = '0, er_row = '0;
    logic [NC-1:0]    ew_info = '0, ersp_data = '0;
    logic [MB-1:0]    ew_old = '0, ew_new = '0;
    logic [TB-1:0]    ersp_tag = '0;
    restart();
    for (int i = 0; i < 400; i++) begin
      total++; if ({bus.him_writeRow, bus.him_readRow} !== {ew, er})
        $display("FAIL rand_cmd cyc=%0d got=%b exp=%b", cyc, {bus.him_writeRow, bus.him_readRow}, {ew, er}); else passed++;
      if (ew) begin
        total++; if (bus.him_inputRowToWrite !== ew_row || bus.him_inputHitInfo !== ew_info || bus.him_nOldHits !== ew_old || bus.him_nNewHits !== ew_new)
          $display("FAIL rand_wr_fields cyc=%0d got row=%0d exp row=%0d", cyc, bus.him_inputRowToWrite, ew_row); else passed++;
      end
      if (er) begin
        total++; if (bus.him_inputRowToRead !== er_row) $display("FAIL rand_rd_row cyc=%0d got=%0d exp=%0d", cyc, bus.him_inputRowToRead, er_row); else passed++;
      end
      total++; if (bus.rsp_valid !== ersp) $display("FAIL rand_rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, ersp); else passed++;
      if (ersp) begin
        total++; if (bus.rsp_data !== ersp_data || bus.rsp_tag !== ersp_tag)
          $display("FAIL rand_rsp cyc=%0d got t=%0d d=%h exp t=%0d d=%h", cyc, bus.rsp_tag, bus.rsp_data, ersp_tag, ersp_data); else passed++;
      end
      total++; if (inflight !== (pend.size() != 0)) $display("FAIL rand_inflight cyc=%0d got=%b exp=%b", cyc, inflight, pend.size() != 0); else passed++;

      if (!w_wait) begin
        bus.wr_valid    = ($urandom_range(0, 99) < 60);
        bus.wr_row      = RB'($urandom_range(0, 7));
        bus.wr_hitInfo  = {$urandom, $urandom, $urandom, $urandom};
        bus.wr_nOldHits = MB'($urandom);
        bus.wr_nNewHits = MB'($urandom);
      end
      if (!r_wait) begin
        bus.rd_valid = ($urandom_range(0, 99) < 60);
        bus.rd_row   = RB'($urandom_range(0, 7));
        bus.rd_tag   = TB'($urandom);
      end
      bus.him_busy         = ($urandom_range(0, 3) == 0);
      bus.him_hitInfo_read = {$urandom, $urandom, $urandom, $urandom};
      #1;

      hz = 1'b0;
`ifdef HIM_ARB_HAZARD_EN
      if (bus.wr_valid && bus.rd_valid && bus.wr_row == bus.rd_row) hz = 1'b1;
      foreach (hrow[k]) if (hrow[k] == int'(bus.rd_row) && cyc - hcyc[k] <= HW) hz = 1'b1;
`endif
      wg = 1'b0; rg = 1'b0;
      if (!bus.him_busy) begin
        if (bus.wr_valid && bus.rd_valid) begin
          if (hz || streak < MWS) wg = 1'b1; else rg = 1'b1;
        end else if (bus.wr_valid) wg = 1'b1;
        else if (bus.rd_valid && !hz) rg = 1'b1;
      end
      total++; if ({bus.wr_ready, bus.rd_ready} !== {wg, rg})
        $display("FAIL rand_grant cyc=%0d got=%b exp=%b", cyc, {bus.wr_ready, bus.rd_ready}, {wg, rg}); else passed++;

      if (rg) streak = 0;
      else if (wg) streak = bus.rd_valid ? ((streak < MWS) ? streak + 1 : MWS) : 0;
      ew = wg; er = rg;
      if (wg) begin
        ew_row = bus.wr_row; ew_info = bus.wr_hitInfo; ew_old = bus.wr_nOldHits; ew_new = bus.wr_nNewHits;
        hrow.push_back(int'(bus.wr_row)); hcyc.push_back(cyc);
      end
      while (hcyc.size() > 0 && cyc - hcyc[0] >= HW) begin
        void'(hrow.pop_front()); void'(hcyc.pop_front());
      end
      if (rg) begin
        er_row = bus.rd_row;
        pend.push_back('{int'(bus.rd_tag), cyc});
      end
      ersp = 1'b0;
      if (pend.size() > 0 && pend[0].g + RL + 1 == cyc) begin
        ersp = 1'b1; ersp_data = bus.him_hitInfo_read; ersp_tag = TB'(pend[0].tag);
        void'(pend.pop_front());
      end
      w_wait = bus.wr_valid && !wg;
      r_wait = bus.rd_valid && !rg;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_starvation();
    test_busy();
    test_hazard();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
